// File: rtl/hilo_muldiv_if.sv
// hilo_muldiv_if: E-stage bundle between the pipeline and the HI/LO multiply-divide unit.
interface hilo_muldiv_if;
  localparam int unsigned W  = 32;
  localparam int unsigned CW = 6;

  logic [CW-1:0] alu_control;
  logic          valid_i;
  logic          flush_i;
  logic [W-1:0]  src_a;
  logic [W-1:0]  src_b;
  logic          busy_o;
  logic [W-1:0]  hi_o;
  logic [W-1:0]  lo_o;
  logic [W-1:0]  result_o;

  modport master (
    output alu_control, valid_i, flush_i, src_a, src_b,
    input  busy_o, hi_o, lo_o, result_o
  );

  modport slave (
    input  alu_control, valid_i, flush_i, src_a, src_b,
    output busy_o, hi_o, lo_o, result_o
  );
endinterface

// File: rtl/hilo_muldiv.sv
// hilo_muldiv: architectural HI/LO plus MULT/MULTU/DIV/DIVU and MTHI/MTLO/MFHI/MFLO for the E stage.
// Optional MUL_ITERATIVE_EN: MULT/MULTU run through the 32-cycle shift-add path instead of a single cycle.
module hilo_muldiv #(
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic         clk,
  input  logic         resetn,
  hilo_muldiv_if.slave bus
);
  localparam int unsigned W  = 32;
  localparam int unsigned CW = $clog2(DIV_CYCLES);

  localparam logic [5:0] ALU_MFHI  = 6'h10;
  localparam logic [5:0] ALU_MTHI  = 6'h11;
  localparam logic [5:0] ALU_MFLO  = 6'h12;
  localparam logic [5:0] ALU_MTLO  = 6'h13;
  localparam logic [5:0] ALU_MULT  = 6'h18;
  localparam logic [5:0] ALU_MULTU = 6'h19;
  localparam logic [5:0] ALU_DIV   = 6'h1A;
  localparam logic [5:0] ALU_DIVU  = 6'h1B;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [W-1:0]  rem_q, quo_q, dvs_q, dvd_raw_q, hi_q, lo_q;
  logic          neg_q_q, neg_r_q, div0_q;
`ifdef MUL_ITERATIVE_EN
  logic          op_div_q;
  logic [W:0]    mul_sum;
  logic [2*W-1:0] prod_mag, prod_fix;
`else
  logic [2*W-1:0] a_ext, b_ext, mul_full;
`endif

  logic          is_mul, is_div, is_signed, live, start, multi, last_iter;
  logic [W-1:0]  a_mag, b_mag;
  logic [W:0]    div_shift;
  logic          div_ge;
  logic [W-1:0]  rem_n, quo_n, fin_hi, fin_lo;

  // Decode and accept; a held reset never requests a stall.
  always_comb begin : decode
    is_mul    = (bus.alu_control == ALU_MULT) || (bus.alu_control == ALU_MULTU);
    is_div    = (bus.alu_control == ALU_DIV)  || (bus.alu_control == ALU_DIVU);
    is_signed = (bus.alu_control == ALU_MULT) || (bus.alu_control == ALU_DIV);
    live      = resetn && bus.valid_i && !bus.flush_i && (state == IDLE);
    start     = live && (is_mul || is_div);
`ifdef MUL_ITERATIVE_EN
    multi     = is_mul || is_div;
`else
    multi     = is_div;
`endif
    a_mag     = (is_signed && bus.src_a[W-1]) ? W'(-bus.src_a) : bus.src_a;
    b_mag     = (is_signed && bus.src_b[W-1]) ? W'(-bus.src_b) : bus.src_b;
    last_iter = (cnt == CW'(DIV_CYCLES - 1));
  end

  // One iteration: restoring divide step, or shift-add multiply step.
  always_comb begin : step
    div_shift = {rem_q, quo_q[W-1]};
    div_ge    = (div_shift >= {1'b0, dvs_q});
    rem_n     = div_ge ? (div_shift[W-1:0] - dvs_q) : div_shift[W-1:0];
    quo_n     = {quo_q[W-2:0], div_ge};
`ifdef MUL_ITERATIVE_EN
    mul_sum   = {1'b0, rem_q} + {1'b0, (quo_q[0] ? dvs_q : {W{1'b0}})};
    if (!op_div_q) begin
      rem_n = mul_sum[W:1];
      quo_n = {mul_sum[0], quo_q[W-1:1]};
    end
`endif
  end

  // Sign fixup and special cases applied to the final iteration's result.
  always_comb begin : finish
    fin_lo = neg_q_q ? W'(-quo_n) : quo_n;
    fin_hi = neg_r_q ? W'(-rem_n) : rem_n;
    if (div0_q) begin
      fin_lo = {W{1'b1}};
      fin_hi = dvd_raw_q;
    end
`ifdef MUL_ITERATIVE_EN
    prod_mag = {rem_n, quo_n};
    prod_fix = neg_q_q ? (2*W)'(-prod_mag) : prod_mag;
    if (!op_div_q) {fin_hi, fin_lo} = prod_fix;
`endif
  end

`ifndef MUL_ITERATIVE_EN
  always_comb begin : single_mul
    a_ext    = is_signed ? {{W{bus.src_a[W-1]}}, bus.src_a} : {{W{1'b0}}, bus.src_a};
    b_ext    = is_signed ? {{W{bus.src_b[W-1]}}, bus.src_b} : {{W{1'b0}}, bus.src_b};
    mul_full = a_ext * b_ext;
  end
`endif

  always_ff @(posedge clk or negedge resetn) begin : seq
    if (!resetn) begin
      state     <= IDLE;
      cnt       <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      dvd_raw_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      div0_q    <= 1'b0;
`ifdef MUL_ITERATIVE_EN
      op_div_q  <= 1'b0;
`endif
    end else if (bus.flush_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && multi) begin
            state     <= RUN;
            cnt       <= '0;
            rem_q     <= '0;
            quo_q     <= is_div ? a_mag : b_mag;
            dvs_q     <= is_div ? b_mag : a_mag;
            dvd_raw_q <= bus.src_a;
            neg_q_q   <= is_signed && (bus.src_a[W-1] ^ bus.src_b[W-1]);
            neg_r_q   <= is_signed && bus.src_a[W-1];
            div0_q    <= is_div && (bus.src_b == '0);
`ifdef MUL_ITERATIVE_EN
            op_div_q  <= is_div;
`endif
          end
`ifndef MUL_ITERATIVE_EN
          else if (start) begin
            hi_q <= mul_full[2*W-1:W];
            lo_q <= mul_full[W-1:0];
          end
`endif
          else if (live && (bus.alu_control == ALU_MTHI)) hi_q <= bus.src_a;
          else if (live && (bus.alu_control == ALU_MTLO)) lo_q <= bus.src_a;
        end
        RUN: begin
          rem_q <= rem_n;
          quo_q <= quo_n;
          cnt   <= cnt + 1'b1;
          if (last_iter) begin
            state <= DONE;
            hi_q  <= fin_hi;
            lo_q  <= fin_lo;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy_o   = (start && multi) || (state == RUN);
  assign bus.hi_o     = hi_q;
  assign bus.lo_o     = lo_q;
  assign bus.result_o = (bus.alu_control == ALU_MFHI) ? hi_q :
                        (bus.alu_control == ALU_MFLO) ? lo_q : '0;
endmodule
